// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the mini CPU control path.
//   - default widths for opcode, ALU function and T-step fields
//   - opcode map for IR[31:27] and ALU function encodings
//   - T-step state enum and the packed control-line bundle (ctrl_t)
//   - alu_of(): ALU function implied by an opcode
package cpu_pkg;

   localparam int DEF_OPCODE_W = 5;
   localparam int DEF_ALU_OP_W = 5;
   localparam int DEF_STEP_W   = 4;

   typedef logic [DEF_OPCODE_W-1:0] opcode_t;
   typedef logic [DEF_ALU_OP_W-1:0] alu_op_t;

   localparam opcode_t OP_LD   = 5'd0;
   localparam opcode_t OP_LDI  = 5'd1;
   localparam opcode_t OP_ST   = 5'd2;
   localparam opcode_t OP_ADD  = 5'd3;
   localparam opcode_t OP_SUB  = 5'd4;
   localparam opcode_t OP_AND  = 5'd5;
   localparam opcode_t OP_OR   = 5'd6;
   localparam opcode_t OP_SHR  = 5'd7;
   localparam opcode_t OP_SHRA = 5'd8;
   localparam opcode_t OP_SHL  = 5'd9;
   localparam opcode_t OP_ROR  = 5'd10;
   localparam opcode_t OP_ROL  = 5'd11;
   localparam opcode_t OP_ADDI = 5'd12;
   localparam opcode_t OP_ANDI = 5'd13;
   localparam opcode_t OP_ORI  = 5'd14;
   localparam opcode_t OP_MUL  = 5'd15;
   localparam opcode_t OP_DIV  = 5'd16;
   localparam opcode_t OP_NEG  = 5'd17;
   localparam opcode_t OP_NOT  = 5'd18;
   localparam opcode_t OP_BR   = 5'd19;
   localparam opcode_t OP_JR   = 5'd20;
   localparam opcode_t OP_JAL  = 5'd21;
   localparam opcode_t OP_IN   = 5'd22;
   localparam opcode_t OP_OUT  = 5'd23;
   localparam opcode_t OP_MFHI = 5'd24;
   localparam opcode_t OP_MFLO = 5'd25;
   localparam opcode_t OP_NOP  = 5'd26;
   localparam opcode_t OP_HALT = 5'd27;

   localparam alu_op_t ALU_NONE = 5'd0;
   localparam alu_op_t ALU_ADD  = 5'd3;
   localparam alu_op_t ALU_SUB  = 5'd4;
   localparam alu_op_t ALU_AND  = 5'd5;
   localparam alu_op_t ALU_OR   = 5'd6;
   localparam alu_op_t ALU_SHR  = 5'd7;
   localparam alu_op_t ALU_SHRA = 5'd8;
   localparam alu_op_t ALU_SHL  = 5'd9;
   localparam alu_op_t ALU_ROR  = 5'd10;
   localparam alu_op_t ALU_ROL  = 5'd11;
   localparam alu_op_t ALU_MUL  = 5'd15;
   localparam alu_op_t ALU_DIV  = 5'd16;
   localparam alu_op_t ALU_NEG  = 5'd17;
   localparam alu_op_t ALU_NOT  = 5'd18;

   // T0..T7 double as the visible step number; RESET/HALT read back as step 0.
   typedef enum logic [DEF_STEP_W-1:0] {
      ST_T0 = 4'd0, ST_T1 = 4'd1, ST_T2 = 4'd2, ST_T3 = 4'd3,
      ST_T4 = 4'd4, ST_T5 = 4'd5, ST_T6 = 4'd6, ST_T7 = 4'd7,
      ST_RESET = 4'd8, ST_HALT = 4'd9
   } state_t;

   typedef struct packed {
      logic    gra, grb, grc, rin, rout, baout, cout;
      logic    pcout, mdrout, zhighout, zlowout, hiout, loout, inportout;
      logic    pcin, irin, yin, zlowin, zhighin, marin, mdrin, hiin, loin, conin, outportin;
      logic    incpc, read, write, clear, run;
      alu_op_t alu_op;
   } ctrl_t;

   function automatic alu_op_t alu_of(input opcode_t op);
      case (op)
         OP_ADD, OP_ADDI: return ALU_ADD;
         OP_SUB:          return ALU_SUB;
         OP_AND, OP_ANDI: return ALU_AND;
         OP_OR,  OP_ORI:  return ALU_OR;
         OP_SHR:          return ALU_SHR;
         OP_SHRA:         return ALU_SHRA;
         OP_SHL:          return ALU_SHL;
         OP_ROR:          return ALU_ROR;
         OP_ROL:          return ALU_ROL;
         OP_MUL:          return ALU_MUL;
         OP_DIV:          return ALU_DIV;
         OP_NEG:          return ALU_NEG;
         OP_NOT:          return ALU_NOT;
         default:         return ALU_NONE;
      endcase
   endfunction

endpackage

// File: rtl/ctrl_step_decode.sv
// ctrl_step_decode: combinational map of (T-step state, opcode, Con_FF) to the
// full control-line bundle.
//   state    in   current sequencer state
//   opcode   in   IR[31:27]
//   con_ff   in   branch condition, gates PCin on the final branch step
//   ctl      out  control lines for this cycle
//   last     out  this step ends the instruction
//   halt_op  out  halt opcode reached its execute step
//   mem_step out  this step drives Read or Write
module ctrl_step_decode
   import cpu_pkg::*;
(
   input  state_t  state,
   input  opcode_t opcode,
   input  logic    con_ff,
   output ctrl_t   ctl,
   output logic    last,
   output logic    halt_op,
   output logic    mem_step
);

   always_comb begin
      ctl     = '0;
      last    = 1'b0;
      halt_op = 1'b0;
      case (state)
         ST_RESET: ctl.clear = 1'b1;
         ST_HALT:  ;
         ST_T0: begin
            ctl.run = 1'b1; ctl.pcout = 1'b1; ctl.marin = 1'b1;
            ctl.incpc = 1'b1; ctl.zlowin = 1'b1;
         end
         ST_T1: begin
            ctl.run = 1'b1; ctl.zlowout = 1'b1; ctl.pcin = 1'b1;
            ctl.read = 1'b1; ctl.mdrin = 1'b1;
         end
         ST_T2: begin
            ctl.run = 1'b1; ctl.mdrout = 1'b1; ctl.irin = 1'b1;
         end
         default: begin
            // T3..T7: execute steps selected by opcode. Any step past the end
            // of a sequence is unreachable; it is marked last so it can't stick.
            ctl.run = 1'b1;
            case (opcode)
               OP_LD, OP_LDI, OP_ST: begin
                  case (state)
                     ST_T3: begin ctl.grb = 1'b1; ctl.baout = 1'b1; ctl.yin = 1'b1; end
                     ST_T4: begin ctl.cout = 1'b1; ctl.alu_op = ALU_ADD; ctl.zlowin = 1'b1; end
                     ST_T5: begin
                        ctl.zlowout = 1'b1;
                        if (opcode == OP_LDI) begin
                           ctl.gra = 1'b1; ctl.rin = 1'b1; last = 1'b1;
                        end else
                           ctl.marin = 1'b1;
                     end
                     ST_T6: begin
                        ctl.mdrin = 1'b1;
                        if (opcode == OP_ST) begin ctl.gra = 1'b1; ctl.rout = 1'b1; end
                        else                 ctl.read = 1'b1;
                     end
                     ST_T7: begin
                        last = 1'b1;
                        if (opcode == OP_ST) ctl.write = 1'b1;
                        else begin ctl.mdrout = 1'b1; ctl.gra = 1'b1; ctl.rin = 1'b1; end
                     end
                     default: last = 1'b1;
                  endcase
               end
               OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA, OP_SHL, OP_ROR, OP_ROL,
               OP_ADDI, OP_ANDI, OP_ORI: begin
                  case (state)
                     ST_T3: begin ctl.grb = 1'b1; ctl.rout = 1'b1; ctl.yin = 1'b1; end
                     ST_T4: begin
                        // immediates take operand B from the sign-extended C field
                        if (opcode inside {OP_ADDI, OP_ANDI, OP_ORI}) ctl.cout = 1'b1;
                        else begin ctl.grc = 1'b1; ctl.rout = 1'b1; end
                        ctl.alu_op = alu_of(opcode); ctl.zlowin = 1'b1;
                     end
                     ST_T5: begin ctl.zlowout = 1'b1; ctl.gra = 1'b1; ctl.rin = 1'b1; last = 1'b1; end
                     default: last = 1'b1;
                  endcase
               end
               OP_MUL, OP_DIV: begin
                  case (state)
                     ST_T3: begin ctl.gra = 1'b1; ctl.rout = 1'b1; ctl.yin = 1'b1; end
                     ST_T4: begin
                        ctl.grb = 1'b1; ctl.rout = 1'b1; ctl.alu_op = alu_of(opcode);
                        ctl.zlowin = 1'b1; ctl.zhighin = 1'b1;
                     end
                     ST_T5: begin ctl.zlowout = 1'b1; ctl.loin = 1'b1; end
                     ST_T6: begin ctl.zhighout = 1'b1; ctl.hiin = 1'b1; last = 1'b1; end
                     default: last = 1'b1;
                  endcase
               end
               OP_NEG, OP_NOT: begin
                  case (state)
                     ST_T3: begin
                        ctl.grb = 1'b1; ctl.rout = 1'b1; ctl.alu_op = alu_of(opcode); ctl.zlowin = 1'b1;
                     end
                     ST_T4: begin ctl.zlowout = 1'b1; ctl.gra = 1'b1; ctl.rin = 1'b1; last = 1'b1; end
                     default: last = 1'b1;
                  endcase
               end
               OP_BR: begin
                  case (state)
                     ST_T3: begin ctl.gra = 1'b1; ctl.rout = 1'b1; ctl.conin = 1'b1; end
                     ST_T4: begin ctl.pcout = 1'b1; ctl.yin = 1'b1; end
                     ST_T5: begin ctl.cout = 1'b1; ctl.alu_op = ALU_ADD; ctl.zlowin = 1'b1; end
                     ST_T6: begin ctl.zlowout = 1'b1; ctl.pcin = con_ff; last = 1'b1; end
                     default: last = 1'b1;
                  endcase
               end
               OP_JR: begin
                  ctl.gra = 1'b1; ctl.rout = 1'b1; ctl.pcin = 1'b1; last = 1'b1;
               end
               OP_JAL: begin
                  // return address goes to R15 through the Grb select
                  if (state == ST_T3) begin
                     ctl.pcout = 1'b1; ctl.grb = 1'b1; ctl.rin = 1'b1;
                  end else begin
                     ctl.gra = 1'b1; ctl.rout = 1'b1; ctl.pcin = 1'b1; last = 1'b1;
                  end
               end
               OP_IN: begin
                  ctl.inportout = 1'b1; ctl.gra = 1'b1; ctl.rin = 1'b1; last = 1'b1;
               end
               OP_OUT: begin
                  ctl.gra = 1'b1; ctl.rout = 1'b1; ctl.outportin = 1'b1; last = 1'b1;
               end
               OP_MFHI: begin
                  ctl.hiout = 1'b1; ctl.gra = 1'b1; ctl.rin = 1'b1; last = 1'b1;
               end
               OP_MFLO: begin
                  ctl.loout = 1'b1; ctl.gra = 1'b1; ctl.rin = 1'b1; last = 1'b1;
               end
               OP_HALT: halt_op = 1'b1;
               default: last = 1'b1;  // nop and undefined opcodes
            endcase
         end
      endcase
      mem_step = ctl.read | ctl.write;
   end

endmodule

// File: rtl/ctrl_unit.sv
// ctrl_unit: hardwired microsequencer for the mini CPU datapath.
// Holds the T-step state, steps fetch/decode/execute and drives every
// data_path control line (decoded in ctrl_step_decode).
//   clock, Reset(active-low async), Stop(halt request), IR, Con_FF  inputs
//   mem_ready  input, only with CTRL_MEM_WAIT_EN: holds Read/Write steps
//   register-select, bus-source, register-load, memory, clear, Run,
//   alu_op and step outputs
// Optional feature macro: CTRL_MEM_WAIT_EN
module ctrl_unit
   import cpu_pkg::*;
#(
   parameter int OPCODE_W = DEF_OPCODE_W,
   parameter int ALU_OP_W = DEF_ALU_OP_W,
   parameter int STEP_W   = DEF_STEP_W
) (
   input  logic                clock,
   input  logic                Reset,
   input  logic                Stop,
   input  logic [31:0]         IR,
   input  logic                Con_FF,
`ifdef CTRL_MEM_WAIT_EN
   input  logic                mem_ready,
`endif
   output logic                Gra, Grb, Grc, Rin, Rout, BAout, Cout,
   output logic                PCout, MDRout, Zhighout, Zlowout, HIout, LOout, InPortout,
   output logic                PCin, IRin, Yin, Zlowin, Zhighin, MARin, MDRin,
   output logic                HIin, LOin, CONin, OutPortin,
   output logic                IncPC, Read, Write, clear,
   output logic                Run,
   output logic [ALU_OP_W-1:0] alu_op,
   output logic [STEP_W-1:0]   step
);

   state_t  state, state_n;
   ctrl_t   ctl;
   logic    last, halt_op, mem_step, hold;
   logic    stop_pend;
   opcode_t opcode;
   logic    unused_ir;

   assign opcode    = opcode_t'(IR[31 -: OPCODE_W]);
   assign unused_ir = ^IR[31-OPCODE_W:0];

   ctrl_step_decode u_dec (
      .state    (state),
      .opcode   (opcode),
      .con_ff   (Con_FF),
      .ctl      (ctl),
      .last     (last),
      .halt_op  (halt_op),
      .mem_step (mem_step)
   );

`ifdef CTRL_MEM_WAIT_EN
   assign hold = mem_step & ~mem_ready;
`else
   assign hold = 1'b0;
   logic unused_mem;
   assign unused_mem = mem_step;
`endif

   always_ff @(posedge clock or negedge Reset) begin
      if (!Reset) state <= ST_RESET;
      else        state <= state_n;
   end

   // A Stop seen mid-instruction is remembered so the instruction can finish
   // and the halt takes effect at its final step.
   always_ff @(posedge clock or negedge Reset) begin
      if (!Reset)                      stop_pend <= 1'b0;
      else if (ctl.run & last & ~hold) stop_pend <= 1'b0;
      else if (ctl.run & Stop)         stop_pend <= 1'b1;
   end

   always_comb begin
      state_n = state;
      case (state)
         ST_RESET: state_n = ST_T0;
         ST_HALT:  state_n = ST_HALT;
         default: begin
            if (hold)         state_n = state;
            else if (halt_op) state_n = ST_HALT;
            else if (last)    state_n = (Stop | stop_pend) ? ST_HALT : ST_T0;
            else              state_n = state_t'(state + 4'd1);
         end
      endcase
   end

   assign step = (state == ST_RESET || state == ST_HALT) ? '0 : STEP_W'(state);

   assign Gra       = ctl.gra;       assign Grb       = ctl.grb;
   assign Grc       = ctl.grc;       assign Rin       = ctl.rin;
   assign Rout      = ctl.rout;      assign BAout     = ctl.baout;
   assign Cout      = ctl.cout;      assign PCout     = ctl.pcout;
   assign MDRout    = ctl.mdrout;    assign Zhighout  = ctl.zhighout;
   assign Zlowout   = ctl.zlowout;   assign HIout     = ctl.hiout;
   assign LOout     = ctl.loout;     assign InPortout = ctl.inportout;
   assign PCin      = ctl.pcin;      assign IRin      = ctl.irin;
   assign Yin       = ctl.yin;       assign Zlowin    = ctl.zlowin;
   assign Zhighin   = ctl.zhighin;   assign MARin     = ctl.marin;
   assign MDRin     = ctl.mdrin;     assign HIin      = ctl.hiin;
   assign LOin      = ctl.loin;      assign CONin     = ctl.conin;
   assign OutPortin = ctl.outportin; assign IncPC     = ctl.incpc;
   assign Read      = ctl.read;      assign Write     = ctl.write;
   assign clear     = ctl.clear;     assign Run       = ctl.run;
   assign alu_op    = ALU_OP_W'(ctl.alu_op);

endmodule

// File: tb/tb_ctrl_unit.sv
// tb_ctrl_unit: table of instructions with per-step expected control vectors,
// queued as a scoreboard and compared each cycle; plus hand sequences for
// Stop, HALT, mid-instruction reset and (with CTRL_MEM_WAIT_EN) memory wait.
module tb_ctrl_unit;
   import cpu_pkg::*;

   logic clock = 1'b0, Reset = 1'b0, Stop = 1'b0, Con_FF = 1'b0;
   logic [31:0] IR = '0;
`ifdef CTRL_MEM_WAIT_EN
   logic mem_ready = 1'b1;
`endif
   logic Gra, Grb, Grc, Rin, Rout, BAout, Cout, PCout, MDRout, Zhighout, Zlowout;
   logic HIout, LOout, InPortout, PCin, IRin, Yin, Zlowin, Zhighin, MARin, MDRin;
   logic HIin, LOin, CONin, OutPortin, IncPC, Read, Write, clear, Run;
   logic [4:0] alu_op;
   logic [3:0] step;

   ctrl_unit dut (
      .clock(clock), .Reset(Reset), .Stop(Stop), .IR(IR), .Con_FF(Con_FF),
`ifdef CTRL_MEM_WAIT_EN
      .mem_ready(mem_ready),
`endif
      .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout), .Cout(Cout),
      .PCout(PCout), .MDRout(MDRout), .Zhighout(Zhighout), .Zlowout(Zlowout),
      .HIout(HIout), .LOout(LOout), .InPortout(InPortout),
      .PCin(PCin), .IRin(IRin), .Yin(Yin), .Zlowin(Zlowin), .Zhighin(Zhighin),
      .MARin(MARin), .MDRin(MDRin), .HIin(HIin), .LOin(LOin), .CONin(CONin),
      .OutPortin(OutPortin), .IncPC(IncPC), .Read(Read), .Write(Write), .clear(clear),
      .Run(Run), .alu_op(alu_op), .step(step)
   );

   always #5 clock = ~clock;

   // observation bit positions
   localparam logic [29:0] GRA = 30'd1 << 0,  GRB = 30'd1 << 1,  GRC = 30'd1 << 2;
   localparam logic [29:0] RIN = 30'd1 << 3,  ROUT = 30'd1 << 4, BAOUT = 30'd1 << 5;
   localparam logic [29:0] COUT = 30'd1 << 6, PCOUT = 30'd1 << 7, MDROUT = 30'd1 << 8;
   localparam logic [29:0] ZHIGHOUT = 30'd1 << 9, ZLOWOUT = 30'd1 << 10, HIOUT = 30'd1 << 11;
   localparam logic [29:0] LOOUT = 30'd1 << 12, INPORTOUT = 30'd1 << 13, PCIN = 30'd1 << 14;
   localparam logic [29:0] IRIN = 30'd1 << 15, YIN = 30'd1 << 16, ZLOWIN = 30'd1 << 17;
   localparam logic [29:0] ZHIGHIN = 30'd1 << 18, MARIN = 30'd1 << 19, MDRIN = 30'd1 << 20;
   localparam logic [29:0] HIIN = 30'd1 << 21, LOIN = 30'd1 << 22, CONIN = 30'd1 << 23;
   localparam logic [29:0] OUTPORTIN = 30'd1 << 24, INCPC = 30'd1 << 25, READ = 30'd1 << 26;
   localparam logic [29:0] WRITE = 30'd1 << 27, CLR = 30'd1 << 28, RUN = 30'd1 << 29;
   localparam logic [38:0] HALT_OBS = 39'd0;
   localparam logic [38:0] RST_OBS  = {4'd0, 5'd0, CLR};

   typedef struct {
      logic [31:0]       ir;
      logic              con;
      int                n;
      logic [7:0][38:0]  exp;
   } vec_t;

   typedef struct {
      int          tag;
      logic [38:0] v;
   } sb_t;

   localparam int NV = 19;
   vec_t tbl [NV];
   sb_t  sb [$];
   int   checks = 0, errors = 0;

   function automatic logic [38:0] obs();
      return {step, alu_op, Run, clear, Write, Read, IncPC, OutPortin, CONin, LOin, HIin,
              MDRin, MARin, Zhighin, Zlowin, Yin, IRin, PCin, InPortout, LOout, HIout,
              Zlowout, Zhighout, MDRout, PCout, Cout, BAout, Rout, Rin, Grc, Grb, Gra};
   endfunction

   function automatic logic [38:0] e(input int s, input logic [4:0] a, input logic [29:0] c);
      return {4'(s), a, c | RUN};
   endfunction

   function automatic logic [31:0] mk(input logic [4:0] op, input int ra, input int rb,
                                      input logic [18:0] low);
      return {op, 4'(ra), 4'(rb), low};
   endfunction

   task automatic chk(input string name, input logic [38:0] got, input logic [38:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", name, got, want);
      end
   endtask

   always @(negedge clock) begin
      if (sb.size() != 0) begin
         sb_t x;
         x = sb.pop_front();
         chk($sformatf("seq%0d_t%0d", x.tag / 10, x.tag % 10), obs(), x.v);
      end
   end

   task automatic tv(input int i, input logic [31:0] ir, input logic con, input int n,
                     input logic [38:0] x3, input logic [38:0] x4, input logic [38:0] x5,
                     input logic [38:0] x6, input logic [38:0] x7);
      tbl[i].ir = ir; tbl[i].con = con; tbl[i].n = n;
      tbl[i].exp[0] = e(0, ALU_NONE, PCOUT | MARIN | INCPC | ZLOWIN);
      tbl[i].exp[1] = e(1, ALU_NONE, ZLOWOUT | PCIN | READ | MDRIN);
      tbl[i].exp[2] = e(2, ALU_NONE, MDROUT | IRIN);
      tbl[i].exp[3] = x3; tbl[i].exp[4] = x4; tbl[i].exp[5] = x5;
      tbl[i].exp[6] = x6; tbl[i].exp[7] = x7;
   endtask

   task automatic push(input int tag, input logic [38:0] v);
      sb_t x;
      x.tag = tag; x.v = v;
      sb.push_back(x);
   endtask

   // wait for the scoreboard to drain; returns 1 ns after the next edge
   task automatic drain(input string name);
      int b = 0;
      while (sb.size() != 0 && b < 100) begin
         @(posedge clock);
         b++;
      end
      if (sb.size() != 0) begin
         checks++; errors++;
         $display("FAIL %s timeout got=%0d entries left exp=0", name, sb.size());
         sb.delete();
      end
      #1;
   endtask

   task automatic do_reset();
      Reset = 1'b0;
      @(negedge clock);
      chk("reset_state", obs(), RST_OBS);
      #2 Reset = 1'b1;
      @(posedge clock);
      #1;
   endtask

   task automatic start(input int v, input int n);
      IR = tbl[v].ir; Con_FF = tbl[v].con;
      for (int s = 0; s < n; s++) push(v * 10 + s, tbl[v].exp[s]);
   endtask

   localparam logic [38:0] Z = 39'd0;

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      tv(0, 32'h18918000, 0, 6, e(3, ALU_NONE, GRB | ROUT | YIN), e(4, ALU_ADD, GRC | ROUT | ZLOWIN),
         e(5, ALU_NONE, ZLOWOUT | GRA | RIN), Z, Z);
      tv(1, mk(OP_LD, 2, 1, 19'h45), 0, 8, e(3, ALU_NONE, GRB | BAOUT | YIN),
         e(4, ALU_ADD, COUT | ZLOWIN), e(5, ALU_NONE, ZLOWOUT | MARIN),
         e(6, ALU_NONE, READ | MDRIN), e(7, ALU_NONE, MDROUT | GRA | RIN));
      tv(2, mk(OP_LDI, 3, 0, 19'h7), 0, 6, e(3, ALU_NONE, GRB | BAOUT | YIN),
         e(4, ALU_ADD, COUT | ZLOWIN), e(5, ALU_NONE, ZLOWOUT | GRA | RIN), Z, Z);
      tv(3, mk(OP_ST, 4, 1, 19'h10), 0, 8, e(3, ALU_NONE, GRB | BAOUT | YIN),
         e(4, ALU_ADD, COUT | ZLOWIN), e(5, ALU_NONE, ZLOWOUT | MARIN),
         e(6, ALU_NONE, GRA | ROUT | MDRIN), e(7, ALU_NONE, WRITE));
      tv(4, mk(OP_ADDI, 1, 2, 19'h5), 0, 6, e(3, ALU_NONE, GRB | ROUT | YIN),
         e(4, ALU_ADD, COUT | ZLOWIN), e(5, ALU_NONE, ZLOWOUT | GRA | RIN), Z, Z);
      tv(5, mk(OP_SUB, 1, 2, 19'(3 << 15)), 0, 6, e(3, ALU_NONE, GRB | ROUT | YIN),
         e(4, ALU_SUB, GRC | ROUT | ZLOWIN), e(5, ALU_NONE, ZLOWOUT | GRA | RIN), Z, Z);
      tv(6, mk(OP_ROR, 7, 8, 19'(9 << 15)), 0, 6, e(3, ALU_NONE, GRB | ROUT | YIN),
         e(4, ALU_ROR, GRC | ROUT | ZLOWIN), e(5, ALU_NONE, ZLOWOUT | GRA | RIN), Z, Z);
      tv(7, mk(OP_MUL, 3, 4, 19'h0), 0, 7, e(3, ALU_NONE, GRA | ROUT | YIN),
         e(4, ALU_MUL, GRB | ROUT | ZLOWIN | ZHIGHIN), e(5, ALU_NONE, ZLOWOUT | LOIN),
         e(6, ALU_NONE, ZHIGHOUT | HIIN), Z);
      tv(8, mk(OP_NEG, 5, 6, 19'h0), 0, 5, e(3, ALU_NEG, GRB | ROUT | ZLOWIN),
         e(4, ALU_NONE, ZLOWOUT | GRA | RIN), Z, Z, Z);
      tv(9, mk(OP_BR, 2, 0, 19'h20), 0, 7, e(3, ALU_NONE, GRA | ROUT | CONIN),
         e(4, ALU_NONE, PCOUT | YIN), e(5, ALU_ADD, COUT | ZLOWIN), e(6, ALU_NONE, ZLOWOUT), Z);
      tv(10, mk(OP_BR, 2, 0, 19'h20), 1, 7, e(3, ALU_NONE, GRA | ROUT | CONIN),
         e(4, ALU_NONE, PCOUT | YIN), e(5, ALU_ADD, COUT | ZLOWIN),
         e(6, ALU_NONE, ZLOWOUT | PCIN), Z);
      tv(11, mk(OP_JR, 6, 0, 19'h0), 0, 4, e(3, ALU_NONE, GRA | ROUT | PCIN), Z, Z, Z, Z);
      tv(12, mk(OP_JAL, 6, 0, 19'h0), 0, 5, e(3, ALU_NONE, PCOUT | GRB | RIN),
         e(4, ALU_NONE, GRA | ROUT | PCIN), Z, Z, Z);
      tv(13, mk(OP_IN, 1, 0, 19'h0), 0, 4, e(3, ALU_NONE, INPORTOUT | GRA | RIN), Z, Z, Z, Z);
      tv(14, mk(OP_OUT, 1, 0, 19'h0), 0, 4, e(3, ALU_NONE, GRA | ROUT | OUTPORTIN), Z, Z, Z, Z);
      tv(15, mk(OP_MFHI, 2, 0, 19'h0), 0, 4, e(3, ALU_NONE, HIOUT | GRA | RIN), Z, Z, Z, Z);
      tv(16, mk(OP_MFLO, 2, 0, 19'h0), 0, 4, e(3, ALU_NONE, LOOUT | GRA | RIN), Z, Z, Z, Z);
      tv(17, mk(OP_NOP, 0, 0, 19'h0), 0, 4, e(3, ALU_NONE, 30'd0), Z, Z, Z, Z);
      tv(18, mk(5'd31, 0, 0, 19'h0), 0, 4, e(3, ALU_NONE, 30'd0), Z, Z, Z, Z);

      #10;
      do_reset();

      // back-to-back table run
      for (int v = 0; v < NV; v++) begin
         start(v, tbl[v].n);
         drain($sformatf("vec%0d", v));
      end

      // Stop raised during T4 of mul: mul completes, then HALT with Run=0
      start(7, 7);
      for (int k = 0; k < 3; k++) push(90 + k, HALT_OBS);
      repeat (4) @(posedge clock);
      #1 Stop = 1'b1;
      @(posedge clock);
      #1 Stop = 1'b0;
      drain("stop_mul");
      do_reset();

      // Stop at the last step of nop halts right after it
      start(17, 4);
      for (int k = 0; k < 2; k++) push(91, HALT_OBS);
      repeat (3) @(posedge clock);
      #1 Stop = 1'b1;
      @(posedge clock);
      #1 Stop = 1'b0;
      drain("stop_nop");
      do_reset();

      // reset in the middle of ld (at T5) aborts it; next instruction runs clean
      start(1, 5);
      drain("ld_partial");
      do_reset();
      start(0, 6);
      drain("add_after_abort");

`ifdef CTRL_MEM_WAIT_EN
      // mem_ready low for 3 cycles during ld T6: Read held 4 cycles, then T7
      IR = tbl[1].ir; Con_FF = 1'b0;
      for (int s = 0; s < 6; s++) push(10 + s, tbl[1].exp[s]);
      for (int k = 0; k < 4; k++) push(16, tbl[1].exp[6]);
      push(17, tbl[1].exp[7]);
      repeat (6) @(posedge clock);
      #1 mem_ready = 1'b0;
      repeat (3) @(posedge clock);
      #1 mem_ready = 1'b1;
      drain("mem_wait");
`endif

      repeat (2) @(posedge clock);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ctrl_unit.md
Name: ctrl_unit

Overview:
- Hardwired microsequencer for the mini CPU datapath.
- Decodes IR[31:27] and steps through fetch, decode and execute T-states.
- Drives every bus-select, register-load, memory and ALU control line of data_path.
- Sits beside data_path in the top-level CPU; IR and CON flip-flop state feed back to it.

Parameters:
- OPCODE_W, 5, width of opcode field IR[31:27]
- ALU_OP_W, 5, width of alu_op output passed to the ALU
- STEP_W, 4, width of the internal T-step counter

Ports:
- clock  in  1  system clock; all state updates on rising edge
- Reset  in  1  asynchronous reset, active-low (asserted at 0)
- Stop  in  1  synchronous halt request
- IR  in  32  instruction register contents from data_path
- Con_FF  in  1  branch-condition flip-flop from data_path
- Gra, Grb, Grc, Rin, Rout, BAout, Cout  out  1 each  register-select/encode controls
- PCout, MDRout, Zhighout, Zlowout, HIout, LOout, InPortout  out  1 each  bus source selects (one-hot or none)
- PCin, IRin, Yin, Zlowin, Zhighin, MARin, MDRin, HIin, LOin, CONin, OutPortin  out  1 each  register loads
- IncPC, Read, Write, clear  out  1 each  PC increment, memory read/write, global datapath clear
- Run  out  1  1 while executing; 0 in HALT/RESET
- alu_op  out  ALU_OP_W  ALU function for current step
- step  out  STEP_W  current T-step (debug visibility)

Behaviour:
- Reset low: state=RESET, all outputs 0 except clear=1; Run=0; step=0. Reset release: next edge enters T0, clear drops to 0.
- States: RESET, T0, T1, T2, T3..T7, HALT. T3 onward are execute steps selected by opcode.
- Fetch: T0 PCout, MARin, IncPC, Zlowin; T1 Zlowout, PCin, Read, MDRin; T2 MDRout, IRin. T3 is the first cycle in which IR is valid for decode.
- Execute sequences (step count incl. fetch), all returning to T0:
  - ld/ldi: T3 Grb, BAout, Yin; T4 Cout, alu_op=ADD, Zlowin; T5 Zlowout, MARin (ldi: Gra, Rin, end); T6 Read, MDRin; T7 MDRout, Gra, Rin.
  - st: T3-T5 as ld; T6 Gra, Rout, MDRin; T7 Write.
  - R-type ALU (add, sub, and, or, shr, shra, shl, ror, rol): T3 Grb, Rout, Yin; T4 Grc, Rout, alu_op, Zlowin; T5 Zlowout, Gra, Rin.
  - Immediate ALU (addi, andi, ori): as R-type, with Cout replacing Grc/Rout at T4.
  - mul/div: T3 Gra, Rout, Yin; T4 Grb, Rout, alu_op, Zlowin, Zhighin; T5 Zlowout, LOin; T6 Zhighout, HIin.
  - neg/not: T3 Grb, Rout, alu_op, Zlowin; T4 Zlowout, Gra, Rin.
  - branch: T3 Gra, Rout, CONin; T4 PCout, Yin; T5 Cout, ADD, Zlowin; T6 Zlowout, PCin only if Con_FF=1.
  - jr: T3 Gra, Rout, PCin. jal: T3 PCout, Grb-as-R15 Rin; T4 Gra, Rout, PCin.
  - in: T3 InPortout, Gra, Rin. out: T3 Gra, Rout, OutPortin. mfhi/mflo: T3 HIout/LOout, Gra, Rin. nop: return to T0 at T3.
  - halt opcode: enter HALT.
- All outputs are Moore outputs decoded from state and IR; at most one bus-source select is high per cycle.
- Stop=1 sampled at the last step of an instruction forces HALT instead of T0; mid-instruction the current instruction completes first.
- HALT: all controls 0, Run=0; exits only via Reset.
- Undefined opcode: treated as nop.
- Reset mid-instruction aborts immediately; no partial write-back beyond the current cycle.

Optional Feature:
- CTRL_MEM_WAIT_EN: adds input mem_ready (1 bit). Steps asserting Read or Write hold (step unchanged, controls held) until mem_ready=1.
- Without the macro, memory steps are single-cycle and the port does not exist.

Decomposition:
- Shared package cpu_pkg: opcode constants, ALU op encodings, T-step state enum, STEP_W/ALU_OP_W defaults.
- Sub-module ctrl_step_decode: combinational (state, opcode) to control vector; ctrl_unit holds the state/step register and sequencing.

Test Plan:
- Reset low 20 ns then high -> clear=1 during reset; first edge after release T0 with PCout=MARin=IncPC=Zlowin=1; Run=1.
- add R1,R2,R3 (IR=0x18918000) -> T3 Grb, Rout, Yin; T4 alu_op=ADD, Zlowin; T5 Gra, Rin; then T0.
- ld R2,0x45(R1) -> 8 cycles total; Read+MDRin at T6; MDRout+Gra+Rin at T7.
- brzr with Con_FF=0 then Con_FF=1 -> PCin at T6 absent, then present.
- Stop=1 asserted during T4 of mul -> mul completes through T6 HIin, then HALT with Run=0; Reset required to resume.
- CTRL_MEM_WAIT_EN, mem_ready low 3 cycles during ld T6 -> Read held 4 cycles; T7 follows mem_ready=1.
